// File: rtl/bit_density_meter.sv
// Accumulates per-word ones counts over a fixed window of valid sums and
// presents each window total, with a threshold flag, on a valid/ready output.
module bit_density_meter #(
   parameter int InBits      = 32,
   parameter int WindowWords = 16,
   localparam int SumBits    = $clog2(InBits + 1),
   localparam int AccBits    = $clog2(InBits * WindowWords + 1),
   localparam int CntBits    = $clog2(WindowWords)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sum_valid,
   input  logic [SumBits-1:0] sum_data,
   input  logic               clear,
   input  logic [AccBits-1:0] threshold,
   input  logic               dout_ready,
   output logic               dout_valid,
   output logic [AccBits-1:0] dout_total,
   output logic               dout_above,
   output logic               overrun,
   output logic [7:0]         drop_count
);

   localparam logic [CntBits-1:0] LastWord = CntBits'(WindowWords - 1);

   logic [AccBits-1:0] acc_q, acc_d;
   logic [CntBits-1:0] wcnt_q, wcnt_d;
   logic               dout_valid_q, dout_valid_d;
   logic [AccBits-1:0] dout_total_q, dout_total_d;
   logic               dout_above_q, dout_above_d;
   logic               overrun_q, overrun_d;
   logic [7:0]         drop_count_q, drop_count_d;

   logic [AccBits-1:0] sum_ext;
   logic [AccBits-1:0] final_total;
   logic               complete;
   logic               load;
   logic               drop;

   // A result loads when the output slot is empty or being emptied this cycle;
   // otherwise the new window is discarded and the held result survives.
   always_comb begin
      sum_ext     = AccBits'(sum_data);
      final_total = acc_q + sum_ext;
      complete    = sum_valid && !clear && (wcnt_q == LastWord);
      load        = complete && (!dout_valid_q || dout_ready);
      drop        = complete && dout_valid_q && !dout_ready;

      // NOTE: every output of this block gets a default first, so no path infers a latch.
      acc_d        = acc_q;
      wcnt_d       = wcnt_q;
      dout_valid_d = dout_valid_q;
      dout_total_d = dout_total_q;
      dout_above_d = dout_above_q;
      overrun_d    = drop;
      drop_count_d = drop_count_q;

      if (clear) begin
         acc_d  = '0;
         wcnt_d = '0;
      end else if (sum_valid) begin
         if (complete) begin
            acc_d  = '0;
            wcnt_d = '0;
         end else begin
            acc_d  = final_total;
            wcnt_d = wcnt_q + 1'b1;
         end
      end

      if (load) begin
         dout_valid_d = 1'b1;
         dout_total_d = final_total;
         dout_above_d = (final_total >= threshold);
      end else if (dout_ready) begin
         dout_valid_d = 1'b0;
      end

      if (drop && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         wcnt_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_total_q <= '0;
         dout_above_q <= 1'b0;
         overrun_q    <= 1'b0;
         drop_count_q <= '0;
      end else begin
         acc_q        <= acc_d;
         wcnt_q       <= wcnt_d;
         dout_valid_q <= dout_valid_d;
         dout_total_q <= dout_total_d;
         dout_above_q <= dout_above_d;
         overrun_q    <= overrun_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_total = dout_total_q;
   assign dout_above = dout_above_q;
   assign overrun    = overrun_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bit_density_meter.sv
// Self-checking bench for bit_density_meter (InBits=32, WindowWords=4): vector
// table of whole windows plus hand sequences, results matched via a scoreboard.
module tb_bit_density_meter;

   localparam int InBits      = 32;
   localparam int WindowWords = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sum_valid = 1'b0;
   logic [5:0] sum_data = '0;
   logic       clear = 1'b0;
   logic [7:0] threshold = '0;
   logic       dout_ready = 1'b1;
   logic       dout_valid;
   logic [7:0] dout_total;
   logic       dout_above;
   logic       overrun;
   logic [7:0] drop_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [3:0][5:0] sums;
      logic            gap;
      logic [7:0]      thr;
      logic [7:0]      total;
      logic            above;
   } vec_t;

   typedef struct packed {
      logic [7:0] total;
      logic       above;
   } res_t;

   vec_t vecs[7];
   res_t exp_q[$];

   bit_density_meter #(.InBits(InBits), .WindowWords(WindowWords)) dut (
      .clk        (clk),
      .rst        (rst),
      .sum_valid  (sum_valid),
      .sum_data   (sum_data),
      .clear      (clear),
      .threshold  (threshold),
      .dout_ready (dout_ready),
      .dout_valid (dout_valid),
      .dout_total (dout_total),
      .dout_above (dout_above),
      .overrun    (overrun),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [5:0] w0, input logic [5:0] w1, input logic [5:0] w2,
                               input logic [5:0] w3, input logic gap, input logic [7:0] thr,
                               input logic [7:0] total, input logic above);
      vec_t v;
      v.sums  = {w3, w2, w1, w0};
      v.gap   = gap;
      v.thr   = thr;
      v.total = total;
      v.above = above;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [5:0] v);
      sum_valid = 1'b1;
      sum_data  = v;
      tick();
      sum_valid = 1'b0;
   endtask

   task automatic expect_result(input logic [7:0] total, input logic above);
      res_t r;
      r.total = total;
      r.above = above;
      exp_q.push_back(r);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Results are compared when the DUT actually transfers them.
   always @(negedge clk) begin
      if (!rst && dout_valid && dout_ready) begin
         check("result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            res_t r;
            r = exp_q.pop_front();
            check("result_total", 32'(dout_total), 32'(r.total));
            check("result_above", 32'(dout_above), 32'(r.above));
         end
      end
   end

   initial begin
      vecs[0] = mk(6'd5,  6'd7,  6'd0,  6'd32, 1'b0, 8'd40,  8'd44,  1'b1);
      vecs[1] = mk(6'd1,  6'd1,  6'd1,  6'd1,  1'b1, 8'd4,   8'd4,   1'b1);
      vecs[2] = mk(6'd1,  6'd1,  6'd1,  6'd1,  1'b1, 8'd5,   8'd4,   1'b0);
      vecs[3] = mk(6'd32, 6'd32, 6'd32, 6'd32, 1'b0, 8'd128, 8'd128, 1'b1);
      vecs[4] = mk(6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 8'd0,   8'd0,   1'b1);
      vecs[5] = mk(6'd0,  6'd0,  6'd0,  6'd0,  1'b1, 8'd1,   8'd0,   1'b0);
      vecs[6] = mk(6'd31, 6'd0,  6'd1,  6'd0,  1'b0, 8'd33,  8'd32,  1'b0);

      // Reset state
      idle(2);
      check("rst_valid",      32'(dout_valid), 32'd0);
      check("rst_total",      32'(dout_total), 32'd0);
      check("rst_above",      32'(dout_above), 32'd0);
      check("rst_overrun",    32'(overrun),    32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      rst = 1'b0;

      // Whole windows from the table, consumer always ready
      dout_ready = 1'b1;
      for (int r = 0; r < 7; r++) begin
         threshold = vecs[r].thr;
         for (int j = 0; j < 4; j++) begin
            if (j == 3) expect_result(vecs[r].total, vecs[r].above);
            send(vecs[r].sums[j]);
            if (j < 3 && vecs[r].gap) idle(3 - j);
         end
         threshold = ~vecs[r].thr;
         check($sformatf("vec%0d_latency", r), 32'(dout_valid), 32'd1);
      end
      idle(2);
      check("table_valid_drops", 32'(dout_valid), 32'd0);
      drain("table_drained");

      // Stalled consumer: second window dropped, first held
      threshold  = 8'd100;
      dout_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) expect_result(8'd128, 1'b1);
         send(6'd32);
         if (k == 3) begin
            threshold = 8'd200;
            check("stall_valid", 32'(dout_valid), 32'd1);
            check("stall_total", 32'(dout_total), 32'd128);
         end else if (k > 3 && k < 7) begin
            check("stall_hold_total", 32'(dout_total), 32'd128);
            check("stall_no_overrun", 32'(overrun),    32'd0);
         end
      end
      check("drop_overrun",    32'(overrun),    32'd1);
      check("drop_count_one",  32'(drop_count), 32'd1);
      check("drop_held_total", 32'(dout_total), 32'd128);
      check("drop_held_above", 32'(dout_above), 32'd1);
      tick();
      check("overrun_pulse_end", 32'(overrun), 32'd0);
      dout_ready = 1'b1;
      tick();
      check("stall_released", 32'(dout_valid), 32'd0);
      drain("stall_drained");

      // Back-to-back windows, ready rises on the second completion cycle
      threshold  = 8'd10;
      dout_ready = 1'b0;
      expect_result(8'd10, 1'b1);
      send(6'd1); send(6'd2); send(6'd3); send(6'd4);
      expect_result(8'd20, 1'b1);
      send(6'd5); send(6'd5); send(6'd5);
      dout_ready = 1'b1;
      send(6'd5);
      check("b2b_valid",    32'(dout_valid), 32'd1);
      check("b2b_overrun0", 32'(overrun),    32'd0);
      tick();
      check("b2b_overrun1", 32'(overrun),    32'd0);
      check("b2b_drops",    32'(drop_count), 32'd1);
      drain("b2b_drained");

      // Clear discards a partial window and its own sum
      threshold = 8'd8;
      send(6'd10); send(6'd10);
      clear = 1'b1; sum_valid = 1'b1; sum_data = 6'd20;
      tick();
      clear = 1'b0; sum_valid = 1'b0;
      expect_result(8'd8, 1'b1);
      send(6'd2); send(6'd2); send(6'd2); send(6'd2);
      drain("clear_drained");
      send(6'd2); send(6'd2); send(6'd2);
      clear = 1'b1;
      send(6'd2);
      clear = 1'b0;
      check("clear_wins_valid", 32'(dout_valid), 32'd0);
      idle(2);
      check("clear_wins_idle",    32'(dout_valid), 32'd0);
      check("clear_keeps_drops",  32'(drop_count), 32'd1);
      threshold = 8'd4;
      expect_result(8'd4, 1'b1);
      send(6'd1); send(6'd1); send(6'd1); send(6'd1);
      drain("after_clear_drained");

      // Reset mid-window
      send(6'd7); send(6'd7); send(6'd7);
      rst = 1'b1;
      tick();
      check("midrst_drops", 32'(drop_count), 32'd0);
      check("midrst_valid", 32'(dout_valid), 32'd0);
      rst = 1'b0;
      threshold = 8'd12;
      expect_result(8'd12, 1'b1);
      send(6'd3); send(6'd3); send(6'd3); send(6'd3);
      drain("midrst_drained");
      check("midrst_drops_after", 32'(drop_count), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bit_density_meter.md
BIT_DENSITY_METER -- requirements
Module: bit_density_meter

Interface
REQ-001 SHALL have parameter InBits, default 32, width of popcount source vector (multiple of 4).
REQ-002 SHALL have parameter WindowWords, default 16, number of valid sums per window (>= 2).
REQ-003 SHALL derive localparam SumBits = clog2(InBits+1), AccBits = clog2(InBits*WindowWords+1), CntBits = clog2(WindowWords).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sum_valid  input  1  sum_data valid this cycle (valid tracks sum_bits pipeline latency upstream).
REQ-007 sum_data  input  SumBits  ones count of one input word.
REQ-008 clear  input  1  synchronous window restart.
REQ-009 threshold  input  AccBits  compare level for window total.
REQ-010 dout_ready  input  1  consumer accepts result.
REQ-011 dout_valid  output  1  result held and valid.
REQ-012 dout_total  output  AccBits  window total ones count.
REQ-013 dout_above  output  1  dout_total >= threshold sampled at window completion.
REQ-014 overrun  output  1  one-cycle pulse: completed window dropped.
REQ-015 drop_count  output  8  saturating count of dropped windows.

Function
REQ-016 SHALL hold accumulator acc (AccBits) and word counter wcnt (CntBits); on sum_valid: acc += sum_data zero-extended, wcnt += 1.
REQ-017 Window completes on the cycle sum_valid is sampled with wcnt == WindowWords-1 (completion cycle).
REQ-018 On completion: final = acc + sum_data; acc <= 0, wcnt <= 0 in the same edge; next window starts with the following sum_valid, no dead cycle.
REQ-019 Result SHALL appear on dout_total/dout_above with dout_valid=1 on the cycle after the completion cycle (latency 1).
REQ-020 dout_above SHALL use threshold value present in the completion cycle; later threshold changes SHALL NOT alter a held result.
REQ-021 Output handshake: transfer when dout_valid && dout_ready; dout_valid deasserts next cycle unless a new result loads.
REQ-022 While dout_valid && !dout_ready, dout_total/dout_above SHALL remain stable; accumulation continues unaffected.
REQ-023 Completion with dout_valid=1 and dout_ready=0: new result dropped, held result kept, overrun=1 next cycle, drop_count += 1 saturating at 255.
REQ-024 Completion with dout_valid=1 and dout_ready=1 same cycle: old result transfers, new result loads, dout_valid stays 1, no overrun.
REQ-025 Completion with dout_valid=0: result loads regardless of dout_ready.
REQ-026 clear: acc <= 0, wcnt <= 0; sum_valid in the clear cycle SHALL be ignored; held output, dout_valid, drop_count unaffected; clear wins over completion in the same cycle (no result produced).
REQ-027 Arithmetic SHALL never overflow: max total InBits*WindowWords fits AccBits.
REQ-028 sum_data values > InBits are outside contract; no checking required.

Reset
REQ-029 rst SHALL set acc=0, wcnt=0, dout_valid=0, dout_total=0, dout_above=0, overrun=0, drop_count=0.
REQ-030 rst SHALL take priority over clear, sum_valid and dout_ready; a window in progress is discarded.
REQ-031 First sum_valid after rst deasserts SHALL count as word 0 of a new window.

Verification (InBits=32, WindowWords=4)
REQ-032 Sums 5,7,0,32 on 4 consecutive valids, threshold=40, dout_ready=1 -> dout_valid one cycle after 4th, dout_total=44, dout_above=1.
REQ-033 Sums 1,1,1,1 with gaps of 0-3 idle cycles between valids, threshold=4 -> dout_total=4, dout_above=1; threshold=5 -> dout_above=0.
REQ-034 dout_ready=0, 8 valids of 32 -> first total 128 held stable, overrun pulse one cycle after 8th valid, drop_count=1; then dout_ready=1 -> 128 transfers.
REQ-035 Back-to-back windows, dout_ready asserted exactly on second completion cycle -> both results delivered, overrun never asserted.
REQ-036 Two valids (10,10), clear, then four valids of 2 -> dout_total=8; clear coincident with 4th valid -> no result.
REQ-037 rst asserted after 3 valids then released, 4 valids of 3 -> dout_total=12, drop_count=0.
